// File: rtl/regfile_mp.sv
// regfile_mp: parameterised multi-port register file.
// Posedge writes, combinational reads with optional same-cycle write bypass,
// optional hardwired-zero register, and a registered write-collision flag.

// One read port: registered contents, overridden by a matching write when
// bypassing, and forced to zero for the hardwired-zero register.
module regfile_mp_rd #(
  parameter int             WIDTH    = 64,
  parameter int             DEPTH    = 32,
  parameter int             AW       = 5,
  parameter int             NWR      = 2,
  parameter int             BYPASS   = 1,
  parameter bit             HAS_ZERO = 1'b1,
  parameter logic [AW-1:0]  ZADDR    = '0
) (
  input  logic                              reset,
  input  logic [DEPTH-1:0][WIDTH-1:0]       mem,
  input  logic [NWR-1:0]                    wv,
  input  logic [NWR-1:0][AW-1:0]            wa,
  input  logic [NWR-1:0][WIDTH-1:0]         wd,
  input  logic [AW-1:0]                     rd_addr,
  output logic [WIDTH-1:0]                  rd_data
);

  // Later ports override earlier ones so the bypass matches write priority.
  always_comb begin
    rd_data = mem[rd_addr];
    if (BYPASS != 0 && !reset) begin
      for (int p = 0; p < NWR; p++) begin
        if (wv[p] && (wa[p] == rd_addr)) rd_data = wd[p];
      end
    end
    if (HAS_ZERO && (rd_addr == ZADDR)) rd_data = '0;
  end

endmodule

module regfile_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*AW-1:0]      wr_addr,
  input  logic [NWR*WIDTH-1:0]   wr_data,
  input  logic [NRD*AW-1:0]      rd_addr,
  output logic [NRD*WIDTH-1:0]   rd_data,
  output logic                   wr_conflict
);

  localparam bit            HAS_ZERO = (ZERO_REG >= 0);
  localparam logic [AW-1:0] ZADDR    = HAS_ZERO ? ZERO_REG[AW-1:0] : '0;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                        conflict_q, conflict_d;

  logic [NWR-1:0][AW-1:0]      wa;
  logic [NWR-1:0][WIDTH-1:0]   wd;
  logic [NWR-1:0]              wv;   // enabled and not aimed at the zero register

  assign wa = wr_addr;
  assign wd = wr_data;

  // Effective write strobes: writes to the zero register are dropped here so
  // storage, bypass and conflict detection all ignore them consistently.
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wv[p] = wr_en[p] && !(HAS_ZERO && (wa[p] == ZADDR));
    end
  end

  // Next-state storage: ports applied in order, so port 1 wins a collision.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NWR; p++) begin
      if (wv[p]) mem_d[wa[p]] = wd[p];
    end
    if (HAS_ZERO) mem_d[ZADDR] = '0;
  end

  generate
    if (NWR > 1) begin : g_conf
      // Collision: both ports hit the same real register this cycle.
      always_comb conflict_d = wv[0] && wv[1] && (wa[0] == wa[1]);
    end else begin : g_noconf
      // A single write port can never collide.
      always_comb conflict_d = 1'b0;
    end
  endgenerate

  // State register; reset beats any write presented on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      conflict_q <= conflict_d;
    end
  end

  assign wr_conflict = conflict_q;

  generate
    for (genvar r = 0; r < NRD; r++) begin : g_rd
      regfile_mp_rd #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NWR(NWR),
        .BYPASS(BYPASS), .HAS_ZERO(HAS_ZERO), .ZADDR(ZADDR)
      ) u_rd (
        .reset   (reset),
        .mem     (mem_q),
        .wv      (wv),
        .wa      (wa),
        .wd      (wd),
        .rd_addr (rd_addr[r*AW +: AW]),
        .rd_data (rd_data[r*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule
